dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters:
//   - port C: the pipeline M stage (loads and stores);
//   - port D: a debug/loader port (memory preload and inspection over the board switches).

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (pipeline C, debug D) and the memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_stall;
   logic          c_rvalid;
   logic [DW-1:0] c_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_stall, c_rvalid, c_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_addr, mem_we, mem_din,
      input  mem_dout
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_stall, c_rvalid, c_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_addr, mem_we, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port C has fixed priority, debug port D is
// forced through after MAX_WAIT consecutive refusals. Read data returns one cycle after grant.
module dmem_arbiter #(
   parameter int AW       = 10,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4,
   parameter int CW       = 3
) (
   input  logic          Clk,
   input  logic          Rst,
   dmem_arbiter_if.slave bus
);
   logic [CW-1:0] wcnt;
   logic [CW-1:0] wcntNext;
   logic          forceD;
   logic          rdPend;
   logic          tagD;

   logic          cGnt;
   logic          dGnt;
   logic [AW-1:0] memAddr;
   logic          memWe;
   logic [DW-1:0] memDin;

   // Force removes C from contention; otherwise C wins whenever it asks.
   assign cGnt = bus.c_req & ~forceD;
   assign dGnt = bus.d_req & ~cGnt;

   always_comb begin
      memAddr = '0;
      memWe   = 1'b0;
      memDin  = '0;
      if (cGnt) begin
         memAddr = bus.c_addr;
         memWe   = bus.c_we;
         memDin  = bus.c_wdata;
      end else if (dGnt) begin
         memAddr = bus.d_addr;
         memWe   = bus.d_we;
         memDin  = bus.d_wdata;
      end
   end

   // A dropped request abandons its claim, so the count clears on ~d_req as well as on grant.
   always_comb begin
      wcntNext = wcnt;
      if (dGnt || !bus.d_req)
         wcntNext = '0;
      else if (wcnt < CW'(MAX_WAIT))
         wcntNext = wcnt + CW'(1);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wcnt   <= '0;
         forceD <= 1'b0;
         rdPend <= 1'b0;
         tagD   <= 1'b0;
      end else begin
         wcnt   <= wcntNext;
         forceD <= (wcntNext == CW'(MAX_WAIT));
         rdPend <= (cGnt | dGnt) & ~memWe;
         if ((cGnt | dGnt) & ~memWe)
            tagD <= dGnt;
      end
   end

   assign bus.c_stall  = bus.c_req & ~cGnt;
   assign bus.d_gnt    = dGnt;
   assign bus.mem_addr = memAddr;
   assign bus.mem_we   = memWe;
   assign bus.mem_din  = memDin;

   assign bus.c_rvalid = rdPend & ~tagD;
   assign bus.d_rvalid = rdPend & tagD;
   assign bus.c_rdata  = (rdPend & ~tagD) ? bus.mem_dout : '0;
   assign bus.d_rdata  = (rdPend & tagD)  ? bus.mem_dout : '0;
endmodule
